serial_add_ctrl: RTL and testbench

//  Sequencer that time-shares one 1-bit full-adder cell across a WIDTH-bit add.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/fa_cell.sv | 20 ++
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared state encoding for the bit-serial add sequencer.
// The optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder built from two half-add stages.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic co,
   output logic s
);

   logic s1;
   logic c1;
   logic c2;

   assign s1 = a ^ b;
   assign c1 = a & b;
   assign s  = s1 ^ c;
   assign c2 = s1 & c;
   assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first, valid/ready on both sides.
// Defining SERIAL_ADD_SUB_EN adds a 'sub' port selecting r = p + ~q + 1.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] q,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   r,
   output logic             busy
);

   // Handshakes: a transfer happens on a posedge where valid && ready are both 1.
   // in_ready is high only in IDLE, out_valid only in DONE; both are pure state decodes.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] p_sh_q, p_sh_d;
   logic [WIDTH-1:0] q_sh_q, q_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH:0]   r_q, r_d;
   logic             sub_q, sub_d;
   logic             sub_in;
   logic             cell_b;
   logic             cell_co;
   logic             cell_s;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   // Subtract feeds the inverted B bit; the +1 comes from the initial carry.
   assign cell_b = q_sh_q[0] ^ sub_q;

   fa_cell u_fa_cell (
      .a  (p_sh_q[0]),
      .b  (cell_b),
      .c  (carry_q),
      .co (cell_co),
      .s  (cell_s)
   );

   always_comb begin
      state_d = state_q;
      p_sh_d  = p_sh_q;
      q_sh_d  = q_sh_q;
      carry_d = carry_q;
      count_d = count_q;
      r_d     = r_q;
      sub_d   = sub_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               p_sh_d  = p;
               q_sh_d  = q;
               sub_d   = sub_in;
               carry_d = sub_in;
               count_d = '0;
               r_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            r_d[count_q] = cell_s;
            carry_d      = cell_co;
            p_sh_d       = p_sh_q >> 1;
            q_sh_d       = q_sh_q >> 1;
            count_d      = count_q + 1'b1;
            if (count_q == CNT_LAST) begin
               r_d[WIDTH] = cell_co;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         p_sh_q  <= '0;
         q_sh_q  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         r_q     <= '0;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_sh_q  <= p_sh_d;
         q_sh_q  <= q_sh_d;
         carry_q <= carry_d;
         count_q <= count_d;
         r_q     <= r_d;
         sub_q   <= sub_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN);
   assign r         = r_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=4, 1 and 8, checked against an arithmetic p+q / p-q model.
// Define SERIAL_ADD_SUB_EN to also exercise the subtract mode.
module tb_serial_add_ctrl;

   logic        clk;
   logic        rst_n;
   logic        iv  [3];
   logic        orr [3];
   logic        sb  [3];
   logic [31:0] p_in [3];
   logic [31:0] q_in [3];
   logic [31:0] r_o [3];
   logic        ov  [3];
   logic        ir  [3];
   logic        bz  [3];
   int          wid [3];

   logic [4:0]  r4;
   logic [1:0]  r1;
   logic [8:0]  r8;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .p(p_in[0][3:0]), .q(q_in[0][3:0]),
`ifdef SERIAL_ADD_SUB_EN
      .sub(sb[0]),
`endif
      .out_valid(ov[0]), .out_ready(orr[0]), .r(r4), .busy(bz[0])
   );

   serial_add_ctrl #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .p(p_in[1][0:0]), .q(q_in[1][0:0]),
`ifdef SERIAL_ADD_SUB_EN
      .sub(sb[1]),
`endif
      .out_valid(ov[1]), .out_ready(orr[1]), .r(r1), .busy(bz[1])
   );

   serial_add_ctrl #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .p(p_in[2][7:0]), .q(q_in[2][7:0]),
`ifdef SERIAL_ADD_SUB_EN
      .sub(sb[2]),
`endif
      .out_valid(ov[2]), .out_ready(orr[2]), .r(r8), .busy(bz[2])
   );

   assign r_o[0] = 32'(r4);
   assign r_o[1] = 32'(r1);
   assign r_o[2] = 32'(r8);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact (WIDTH+1)-bit sum, or p + ~q + 1 when subtracting.
   function automatic longint model(input int w, input longint a, input longint b, input bit s);
      longint mask;
      longint res;
      mask = (longint'(1) << w) - 1;
      if (s) res = (a & mask) + ((~b) & mask) + 1;
      else   res = (a & mask) + (b & mask);
      return res & ((longint'(1) << (w + 1)) - 1);
   endfunction

   // One full transaction on DUT 'sel'; 'hold' cycles of backpressure in DONE.
   task automatic do_op(input int sel, input longint a, input longint b, input bit s, input int hold);
      int     w;
      int     n;
      longint exp;
      logic [31:0] r_held;
      w   = wid[sel];
      exp = model(w, a, b, s);
      check($sformatf("in_ready_idle[%0d]", sel), 64'(ir[sel]), 64'd1);
      p_in[sel] = 32'(a);
      q_in[sel] = 32'(b);
      sb[sel]   = s;
      iv[sel]   = 1'b1;
      orr[sel]  = (hold == 0);
      tick();
      iv[sel]   = 1'b0;
      p_in[sel] = $urandom;
      q_in[sel] = $urandom;
      check($sformatf("busy_after_accept[%0d]", sel), 64'(bz[sel]), 64'd1);
      n = 0;
      while (!ov[sel] && n < w + 5) begin
         tick();
         n++;
      end
      check($sformatf("latency[%0d]", sel), 64'(n), 64'(w));
      check($sformatf("result[%0d] %0h%s%0h", sel, a, s ? "-" : "+", b), 64'(r_o[sel]), 64'(exp));
      check($sformatf("done_flags[%0d]", sel), {62'd0, ir[sel], bz[sel]}, 64'd0);
      r_held = r_o[sel];
      for (int k = 0; k < hold; k++) begin
         iv[sel]   = ~iv[sel];
         p_in[sel] = $urandom;
         q_in[sel] = $urandom;
         tick();
         check($sformatf("hold_r[%0d]", sel), 64'(r_o[sel]), 64'(r_held));
         check($sformatf("hold_flags[%0d]", sel), {61'd0, ov[sel], ir[sel], bz[sel]}, 64'b100);
      end
      if (hold != 0) begin
         iv[sel]  = 1'b0;
         orr[sel] = 1'b1;
         tick();
      end else begin
         tick();
      end
      check($sformatf("back_to_idle[%0d]", sel), {62'd0, ir[sel], ov[sel]}, 64'b10);
      orr[sel] = 1'b0;
   endtask

   initial begin
      wid[0] = 4;
      wid[1] = 1;
      wid[2] = 8;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; orr[i] = 1'b0; sb[i] = 1'b0;
         p_in[i] = '0; q_in[i] = '0;
      end
      rst_n = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_r[%0d]", i), 64'(r_o[i]), 64'd0);
         check($sformatf("reset_flags[%0d]", i), {61'd0, ov[i], bz[i], ir[i]}, 64'b001);
      end
      rst_n = 1'b1;
      tick();

      // Directed cases at WIDTH=4.
      do_op(0, 'b1011, 'b0110, 1'b0, 0);
      do_op(0, 'b1111, 'b1111, 1'b0, 0);
      do_op(0, 'b0000, 'b0000, 1'b0, 0);
      do_op(0, 'b1001, 'b0011, 1'b0, 5);

      // Reset on the second RUN cycle abandons the operation.
      p_in[0] = 'b1111; q_in[0] = 'b0001; iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      tick();
      check("mid_run_busy", 64'(bz[0]), 64'd1);
      rst_n = 1'b0;
      tick();
      check("mid_run_reset_r", 64'(r_o[0]), 64'd0);
      check("mid_run_reset_flags", {61'd0, ov[0], bz[0], ir[0]}, 64'b001);
      rst_n = 1'b1;
      tick();
      do_op(0, 'b0111, 'b1110, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
      do_op(0, 'b0101, 'b0111, 1'b1, 0);
      do_op(0, 'b0111, 'b0101, 1'b1, 1);
      do_op(0, 'b1100, 'b0100, 1'b0, 0);
`endif

      // WIDTH=1: single-cycle RUN.
      do_op(1, 1, 1, 1'b0, 0);
      do_op(1, 1, 0, 1'b0, 2);

      // Random sweep at WIDTH=8, plus a few at WIDTH=4 and 1.
      for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_ADD_SUB_EN
         do_op(2, longint'($urandom_range(255)), longint'($urandom_range(255)),
               1'($urandom_range(1)), int'($urandom_range(2)));
`else
         do_op(2, longint'($urandom_range(255)), longint'($urandom_range(255)),
               1'b0, int'($urandom_range(2)));
`endif
      end
      for (int i = 0; i < 6; i++) begin
         do_op(0, longint'($urandom_range(15)), longint'($urandom_range(15)), 1'b0,
               int'($urandom_range(1)));
         do_op(1, longint'($urandom_range(1)), longint'($urandom_range(1)), 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
